// File: rtl/execute_pkg.sv
// Shared types for the RV32 execute stage: ALU op encoding, forwarding selects,
// divider FSM states and branch funct3 codes.
package execute_pkg;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_AND   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_XOR   = 5'd4,
      ALU_SLT   = 5'd5,
      ALU_SLTU  = 5'd6,
      ALU_SLL   = 5'd7,
      ALU_SRL   = 5'd8,
      ALU_SRA   = 5'd9,
      ALU_PASSB = 5'd10,
      ALU_DIV   = 5'd11,
      ALU_DIVU  = 5'd12,
      ALU_REM   = 5'd13,
      ALU_REMU  = 5'd14
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_REG     = 2'b00,
      FWD_WB      = 2'b01,
      FWD_MEM     = 2'b10,
      FWD_REG_ALT = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   function automatic logic isDivOp(input alu_op_e op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

endpackage

// File: rtl/execute_stage_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. Works on magnitudes and
// applies the recorded signs when the result is presented in DONE.
module serial_divider
   import execute_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0]   LAST_COUNT = CW'(DIV_CYCLES - 1);
   localparam logic [XLEN-1:0] MIN_NEG    = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e      state, nextState;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] quo, rem, dvsr;
   logic            negQ, negR, isRem;

   logic            signedOp, remOp, divZero, overflow;
   logic [XLEN-1:0] absA, absB;
   logic [XLEN:0]   partial, trial;
   logic            fits;
   logic [XLEN-1:0] newRem, newQuo;

   // Operand classification and one restoring step on the current registers
   always_comb begin
      signedOp = (op == ALU_DIV) || (op == ALU_REM);
      remOp    = (op == ALU_REM) || (op == ALU_REMU);
      divZero  = (b == '0);
      overflow = signedOp && (a == MIN_NEG) && (b == '1);
      absA     = (signedOp && a[XLEN-1]) ? -a : a;
      absB     = (signedOp && b[XLEN-1]) ? -b : b;
      partial  = {rem, quo[XLEN-1]};
      trial    = partial - {1'b0, dvsr};
      fits     = ~trial[XLEN];
      newRem   = fits ? trial[XLEN-1:0] : partial[XLEN-1:0];
      newQuo   = {quo[XLEN-2:0], fits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DIV_IDLE;
         count <= '0;
         quo   <= '0;
         rem   <= '0;
         dvsr  <= '0;
         negQ  <= 1'b0;
         negR  <= 1'b0;
         isRem <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            DIV_IDLE: begin
               if (start && !flush) begin
                  isRem <= remOp;
                  count <= '0;
                  // Special cases preload the final answer with no sign fix-up
                  if (divZero) begin
                     quo  <= '1;
                     rem  <= a;
                     negQ <= 1'b0;
                     negR <= 1'b0;
                  end else if (overflow) begin
                     quo  <= MIN_NEG;
                     rem  <= '0;
                     negQ <= 1'b0;
                     negR <= 1'b0;
                  end else begin
                     quo  <= absA;
                     rem  <= '0;
                     dvsr <= absB;
                     negQ <= signedOp & (a[XLEN-1] ^ b[XLEN-1]);
                     negR <= signedOp & a[XLEN-1];
                  end
               end
            end
            DIV_BUSY: begin
               if (!flush) begin
                  quo   <= newQuo;
                  rem   <= newRem;
                  count <= count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nextState = state;
      busy      = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (start && !flush) begin
               busy      = 1'b1;
               nextState = (divZero || overflow) ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            busy = 1'b1;
            if (count == LAST_COUNT) nextState = DIV_DONE;
         end
         DIV_DONE: nextState = DIV_IDLE;
         default:  nextState = DIV_IDLE;
      endcase
      if (flush) begin
         nextState = DIV_IDLE;
         busy      = 1'b0;
      end
      // Stall must not be requested while the core is held in reset
      busy = busy & rst_n;
   end

   always_comb begin
      done   = (state == DIV_DONE);
      result = '0;
      if (done) begin
         if (isRem) result = negR ? -rem : rem;
         else       result = negQ ? -quo : quo;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the pipelined RV32 core: forwarding muxes, single-cycle ALU,
// branch/jump resolution and the serial divider with its pipeline stall.
module execute_stage
   import execute_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] ImmExt_E,
   input  logic [XLEN-1:0] PC_Plus4E,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] ResultW,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic            ALUSrcE,
   input  logic [4:0]      ALUControlE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic [2:0]      Funct3E,
   input  logic            FlushE,
   output logic [XLEN-1:0] ALUResultE,
   output logic [XLEN-1:0] WriteDataE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            PCSrcE,
   output logic            DivStallE
);

   localparam int SHW = $clog2(XLEN);

   alu_op_e         aluOp;
   logic [XLEN-1:0] srcA, srcB, aluOut, jalrSum;
   logic [SHW-1:0]  shamt;
   logic            cond;
   logic            divDone;
   logic [XLEN-1:0] divResult;

   assign aluOp = alu_op_e'(ALUControlE);

   always_comb begin
      srcA = RD1E;
      case (fwd_sel_e'(ForwardAE))
         FWD_MEM: srcA = ALUResultM;
         FWD_WB:  srcA = ResultW;
         default: srcA = RD1E;
      endcase
      WriteDataE = RD2E;
      case (fwd_sel_e'(ForwardBE))
         FWD_MEM: WriteDataE = ALUResultM;
         FWD_WB:  WriteDataE = ResultW;
         default: WriteDataE = RD2E;
      endcase
      srcB  = ALUSrcE ? ImmExt_E : WriteDataE;
      shamt = srcB[SHW-1:0];
   end

   serial_divider #(
      .XLEN      (XLEN),
      .DIV_CYCLES(DIV_CYCLES)
   ) uDivider (
      .clk   (clk),
      .rst_n (rst_n),
      .start (isDivOp(aluOp)),
      .op    (aluOp),
      .a     (srcA),
      .b     (srcB),
      .flush (FlushE),
      .busy  (DivStallE),
      .done  (divDone),
      .result(divResult)
   );

   always_comb begin
      aluOut = '0;
      case (aluOp)
         ALU_ADD:   aluOut = srcA + srcB;
         ALU_SUB:   aluOut = srcA - srcB;
         ALU_AND:   aluOut = srcA & srcB;
         ALU_OR:    aluOut = srcA | srcB;
         ALU_XOR:   aluOut = srcA ^ srcB;
         ALU_SLT:   aluOut = {{(XLEN-1){1'b0}}, $signed(srcA) < $signed(srcB)};
         ALU_SLTU:  aluOut = {{(XLEN-1){1'b0}}, srcA < srcB};
         ALU_SLL:   aluOut = srcA << shamt;
         ALU_SRL:   aluOut = srcA >> shamt;
         ALU_SRA:   aluOut = XLEN'($signed(srcA) >>> shamt);
         ALU_PASSB: aluOut = srcB;
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                    aluOut = divDone ? divResult : '0;
         default:   aluOut = '0;
      endcase
   end

   // Branches compare the forwarded rs1/rs2 values, independent of ALUSrcE
   always_comb begin
      cond = 1'b0;
      case (Funct3E)
         F3_BEQ:  cond = (srcA == WriteDataE);
         F3_BNE:  cond = (srcA != WriteDataE);
         F3_BLT:  cond = ($signed(srcA) <  $signed(WriteDataE));
         F3_BGE:  cond = ($signed(srcA) >= $signed(WriteDataE));
         F3_BLTU: cond = (srcA <  WriteDataE);
         F3_BGEU: cond = (srcA >= WriteDataE);
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      jalrSum    = srcA + ImmExt_E;
      PCTargetE  = JalrE ? {jalrSum[XLEN-1:1], 1'b0} : (PCE + ImmExt_E);
      PCSrcE     = (JumpE | (BranchE & cond)) & ~FlushE & ~DivStallE;
      ALUResultE = JumpE ? PC_Plus4E : aluOut;
   end

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: stimulus queues expected results,
// a monitor retires each instruction when the stall drops and compares.
module tb_execute_stage;
   import execute_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] alu;
      logic        pcSrc;
      logic [31:0] target;
      bit          chkTarget;
      int          stalls;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] RD1E, RD2E, PCE, ImmExt_E, PC_Plus4E, ALUResultM, ResultW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        ALUSrcE;
   logic [4:0]  ALUControlE;
   logic        BranchE, JumpE, JalrE;
   logic [2:0]  Funct3E;
   logic        FlushE;
   logic [31:0] ALUResultE, WriteDataE, PCTargetE;
   logic        PCSrcE, DivStallE;

   logic        instrValid;
   int          testCount;
   int          failCount;
   int          stallCnt;
   exp_t        expQ[$];

   execute_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RD1E       (RD1E),
      .RD2E       (RD2E),
      .PCE        (PCE),
      .ImmExt_E   (ImmExt_E),
      .PC_Plus4E  (PC_Plus4E),
      .ALUResultM (ALUResultM),
      .ResultW    (ResultW),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .ALUSrcE    (ALUSrcE),
      .ALUControlE(ALUControlE),
      .BranchE    (BranchE),
      .JumpE      (JumpE),
      .JalrE      (JalrE),
      .Funct3E    (Funct3E),
      .FlushE     (FlushE),
      .ALUResultE (ALUResultE),
      .WriteDataE (WriteDataE),
      .PCTargetE  (PCTargetE),
      .PCSrcE     (PCSrcE),
      .DivStallE  (DivStallE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input string n, input logic [31:0] alu, input logic pcs,
                               input logic [31:0] tgt, input bit chk, input int st);
      exp_t e;
      e.name = n; e.alu = alu; e.pcSrc = pcs; e.target = tgt; e.chkTarget = chk; e.stalls = st;
      return e;
   endfunction

   task automatic clearInputs();
      RD1E = '0; RD2E = '0; PCE = '0; ImmExt_E = '0; PC_Plus4E = '0;
      ALUResultM = '0; ResultW = '0; ForwardAE = 2'b00; ForwardBE = 2'b00;
      ALUSrcE = 1'b0; ALUControlE = ALU_ADD; BranchE = 1'b0; JumpE = 1'b0;
      JalrE = 1'b0; Funct3E = 3'b000; FlushE = 1'b0;
   endtask

   task automatic setAlu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      clearInputs();
      ALUControlE = op;
      RD1E = a;
      RD2E = b;
   endtask

   // Hold the current instruction in EX until the stall drops, bounded
   task automatic applyStimulus(input exp_t e);
      bit retired;
      retired = 1'b0;
      expQ.push_back(e);
      instrValid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!DivStallE) begin
            retired = 1'b1;
            break;
         end
      end
      if (!retired) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL %s.timeout: stall still 1 after 100 cycles, expected release", e.name);
         expQ.delete(expQ.size() - 1);
         FlushE = 1'b1;
      end
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      FlushE = 1'b0;
   endtask

   // Monitor: counts stall cycles and retires one expectation per completed instruction
   initial begin
      exp_t e;
      stallCnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !instrValid || FlushE) begin
            stallCnt = 0;
         end else if (DivStallE) begin
            stallCnt++;
         end else begin
            if (expQ.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL unexpected_retire: got result 0x%08h, expected no instruction", ALUResultE);
            end else begin
               e = expQ.pop_front();
               checkOutput({e.name, ".result"}, ALUResultE, e.alu);
               checkOutput({e.name, ".pcsrc"}, {31'b0, PCSrcE}, {31'b0, e.pcSrc});
               if (e.chkTarget) checkOutput({e.name, ".target"}, PCTargetE, e.target);
               checkOutput({e.name, ".stalls"}, stallCnt, e.stalls);
            end
            stallCnt = 0;
         end
      end
   end

   initial begin
      testCount = 0;
      failCount = 0;
      instrValid = 1'b0;
      clearInputs();
      rst_n = 1'b0;
      RD1E = 32'd3;
      RD2E = 32'd4;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.stall", {31'b0, DivStallE}, 32'd0);
      checkOutput("reset.state", {30'b0, dut.uDivider.state}, {30'b0, DIV_IDLE});
      checkOutput("reset.comb_add", ALUResultE, 32'd7);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding and ALU
      setAlu(ALU_ADD, 32'd99, 32'd7); ForwardAE = 2'b10; ALUResultM = 32'd5;
      applyStimulus(mk("add_fwd_mem", 32'd12, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_XOR, 32'h0000F0F0, 32'd1); ForwardBE = 2'b01; ResultW = 32'h00000FF0;
      applyStimulus(mk("xor_fwd_wb", 32'h0000FF00, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_SRA, 32'h80000000, 32'd0); ALUSrcE = 1'b1; ImmExt_E = 32'd4;
      applyStimulus(mk("sra_imm", 32'hF8000000, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_SLL, 32'd1, 32'h00000023);
      applyStimulus(mk("sll_b40", 32'd8, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_SLTU, 32'd1, 32'hFFFFFFFF);
      applyStimulus(mk("sltu", 32'd1, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_SLT, 32'd1, 32'hFFFFFFFF);
      applyStimulus(mk("slt", 32'd0, 1'b0, 32'd0, 1'b0, 0));
      setAlu(ALU_PASSB, 32'd1, 32'd2); ALUSrcE = 1'b1; ImmExt_E = 32'h00000ABC;
      applyStimulus(mk("passb", 32'h00000ABC, 1'b0, 32'd0, 1'b0, 0));

      // Branches and jumps
      setAlu(ALU_SUB, 32'hFFFFFFFF, 32'd1); BranchE = 1'b1; Funct3E = F3_BLT;
      PCE = 32'h100; ImmExt_E = 32'h20;
      applyStimulus(mk("blt", 32'hFFFFFFFE, 1'b1, 32'h120, 1'b1, 0));
      setAlu(ALU_SUB, 32'hFFFFFFFF, 32'd1); BranchE = 1'b1; Funct3E = F3_BLTU;
      PCE = 32'h100; ImmExt_E = 32'h20;
      applyStimulus(mk("bltu", 32'hFFFFFFFE, 1'b0, 32'h120, 1'b1, 0));
      setAlu(ALU_SUB, 32'hFFFFFFFF, 32'd1); BranchE = 1'b1; Funct3E = F3_BGEU;
      PCE = 32'h100; ImmExt_E = 32'h20;
      applyStimulus(mk("bgeu", 32'hFFFFFFFE, 1'b1, 32'h120, 1'b1, 0));
      setAlu(ALU_SUB, 32'd5, 32'd5); BranchE = 1'b1; Funct3E = 3'b010;
      PCE = 32'h400; ImmExt_E = 32'h8;
      applyStimulus(mk("br_undef_f3", 32'd0, 1'b0, 32'h408, 1'b1, 0));
      setAlu(ALU_ADD, 32'd0, 32'd0); JumpE = 1'b1;
      PCE = 32'h200; ImmExt_E = 32'h40; PC_Plus4E = 32'h204;
      applyStimulus(mk("jal", 32'h204, 1'b1, 32'h240, 1'b1, 0));
      setAlu(ALU_ADD, 32'd0, 32'd0); JumpE = 1'b1; JalrE = 1'b1; ALUSrcE = 1'b1;
      ForwardAE = 2'b01; ResultW = 32'h1001; ImmExt_E = 32'h10;
      PCE = 32'h300; PC_Plus4E = 32'h304;
      applyStimulus(mk("jalr", 32'h304, 1'b1, 32'h1010, 1'b1, 0));

      // Divider, back-to-back and special cases
      setAlu(ALU_DIV, 32'hFFFFFFF9, 32'd2);
      applyStimulus(mk("div_neg", 32'hFFFFFFFD, 1'b0, 32'd0, 1'b0, 33));
      setAlu(ALU_REM, 32'hFFFFFFF9, 32'd2);
      applyStimulus(mk("rem_neg", 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 33));
      setAlu(ALU_DIVU, 32'hFFFFFFFF, 32'h10);
      applyStimulus(mk("divu_big", 32'h0FFFFFFF, 1'b0, 32'd0, 1'b0, 33));
      setAlu(ALU_DIVU, 32'h1234, 32'd0);
      applyStimulus(mk("divu_zero", 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, 1));
      setAlu(ALU_REMU, 32'h1234, 32'd0);
      applyStimulus(mk("remu_zero", 32'h1234, 1'b0, 32'd0, 1'b0, 1));
      setAlu(ALU_REM, 32'h80000000, 32'hFFFFFFFF);
      applyStimulus(mk("rem_ovf", 32'd0, 1'b0, 32'd0, 1'b0, 1));
      setAlu(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
      applyStimulus(mk("div_ovf", 32'h80000000, 1'b0, 32'd0, 1'b0, 1));

      // Flush in the middle of a divide
      setAlu(ALU_DIVU, 32'd50, 32'd3);
      instrValid = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      checkOutput("flush.stall_before", {31'b0, DivStallE}, 32'd1);
      FlushE = 1'b1;
      instrValid = 1'b0;
      #1;
      checkOutput("flush.stall_same_cycle", {31'b0, DivStallE}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("flush.state_idle", {30'b0, dut.uDivider.state}, {30'b0, DIV_IDLE});
      setAlu(ALU_DIVU, 32'd100, 32'd7);
      applyStimulus(mk("divu_after_flush", 32'd14, 1'b0, 32'd0, 1'b0, 33));

      // Reset in the middle of a divide
      setAlu(ALU_DIV, 32'd1000, 32'd3);
      instrValid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      instrValid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid.stall", {31'b0, DivStallE}, 32'd0);
      checkOutput("rst_mid.state", {30'b0, dut.uDivider.state}, {30'b0, DIV_IDLE});
      checkOutput("rst_mid.div_result", ALUResultE, 32'd0);
      setAlu(ALU_ADD, 32'd20, 32'd22);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(mk("add_after_reset", 32'd42, 1'b0, 32'd0, 1'b0, 0));

      checkOutput("scoreboard_empty", expQ.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX-stage datapath of the hazard-aware pipelined RV32 core. It consumes the ID/EX register outputs and produces ALU result, store data and branch/jump redirect for the EX/MEM register.
- Contains operand forwarding muxes, a single-cycle ALU, branch resolution, and an iterative 32-cycle divider for DIV/DIVU/REM/REMU.
- While a divide is in progress, the divider holds the pipeline through a stall request to the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- DIV_CYCLES, 32, divider iterations; must equal XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- RD1E, RD2E  in  XLEN  register operands from ID/EX.
- PCE, ImmExt_E, PC_Plus4E  in  XLEN  PC, extended immediate, PC+4 from ID/EX.
- ALUResultM  in  XLEN  forwarding source from MEM.
- ResultW  in  XLEN  forwarding source from WB.
- ForwardAE, ForwardBE  in  2  00 = register, 10 = ALUResultM, 01 = ResultW, 11 = register.
- ALUSrcE  in  1  1 selects ImmExt_E as operand B.
- ALUControlE  in  5  op code; encoding lives in the package.
- BranchE, JumpE, JalrE  in  1  control-flow type.
- Funct3E  in  3  branch condition.
- FlushE  in  1  kill the EX instruction and abort any divide.
- ALUResultE  out  XLEN  result to EX/MEM.
- WriteDataE  out  XLEN  forwarded rs2 value, used as store data.
- PCTargetE  out  XLEN  branch/jump target.
- PCSrcE  out  1  redirect taken.
- DivStallE  out  1  stall request to the hazard unit.

Behaviour:
- Operand A is the ForwardAE mux output. WriteDataE is the ForwardBE mux output. Operand B is ImmExt_E when ALUSrcE = 1, otherwise WriteDataE.
- ALU ops are combinational with 0-cycle latency: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB. Shift amount is B[4:0]. SLT/SLTU return 0 or 1, zero-extended.
- PCTargetE = PCE + ImmExt_E, except for JALR: (A + ImmExt_E) with bit 0 cleared.
- PCSrcE = JumpE | (BranchE & cond). cond is selected by Funct3E: BEQ, BNE, BLT, BGE, BLTU, BGEU. Undefined Funct3E gives cond = 0.
- PCSrcE is forced to 0 while FlushE = 1 or DivStallE = 1.
- For JumpE, ALUResultE = PC_Plus4E.
- Divider FSM has states IDLE, BUSY, DONE. Reset state is IDLE; counter = 0; quotient and remainder registers = 0.
- IDLE: a div op presented with FlushE = 0 asserts DivStallE combinationally.
  - Next state is BUSY with operands latched. Signed ops latch magnitudes and record the result signs.
  - Divide by zero or signed overflow (-2^31 / -1) skips to DONE with the special result preloaded.
- BUSY: one restoring shift-subtract step per cycle, DIV_CYCLES steps. DivStallE = 1. Enter DONE when counter reaches DIV_CYCLES-1.
- DONE: DivStallE = 0. ALUResultE = the sign-corrected quotient or remainder. Next state is IDLE.
  - The hazard unit advances the pipeline on this edge, so a back-to-back div starts from IDLE on the following cycle.
- Normal divide latency: the instruction occupies EX for 34 cycles (IDLE + 32 BUSY + DONE). Special cases occupy EX for 2 cycles.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
  - Remainder sign follows the dividend.
- FlushE in any state forces the FSM to IDLE on the next edge and drops DivStallE in the same cycle.
- Reset asserted mid-divide clears the FSM immediately. All outputs settle to combinational functions of the inputs; DivStallE = 0.
- In IDLE/BUSY, ALUResultE for a div op is don't-care, but is driven as 0 to keep waveforms clean.

Decomposition:
- Package execute_pkg holds:
  - the alu_op_e enum for ALUControlE;
  - the fwd_sel_e enum;
  - the div_state_e enum;
  - the funct3 branch constants.
- Sub-module serial_divider holds the FSM, counter and sign handling.
  - Inputs: start, op, a, b, flush.
  - Outputs: busy, done, result.
- execute_stage wraps serial_divider with the muxes, ALU and branch logic.

Test Plan:
- ADD with ForwardAE=10, ALUResultM=5, RD2E=7, ALUSrcE=0 -> ALUResultE=12, DivStallE=0.
- BLT with A=0xFFFFFFFF, B=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120. Same operands with BLTU -> PCSrcE=0.
- DIV 0xFFFFFFF9 / 2 -> DivStallE high for 33 cycles, then in DONE ALUResultE=0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF.
- DIVU x / 0 -> 0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF -> 0. Each completes in DONE after one stall cycle.
- FlushE pulsed at BUSY iteration 10 -> DivStallE=0 the same cycle, FSM in IDLE next cycle. A new DIVU 100/7 then yields 14 after full latency.
- rst_n dropped mid-BUSY, then released -> DivStallE=0 during reset and FSM in IDLE. A subsequent ADD works with 0 stall.
